// File: rtl/fetch_unit.sv
// Instruction fetch stage: holds the PC, issues word reads to a 1-cycle
// synchronous instruction memory, buffers returned words with their PC in a
// small FIFO and hands them to decode over a valid/ready handshake.
// Redirects from execute flush the buffer and restart fetch at the target.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW+1:0] DEPTH_OCC = (AW+2)'(DEPTH);

  logic [31:0]   pc_q, pc_d;
  logic          inflight_q, inflight_d;
  logic [31:0]   inflightPc_q, inflightPc_d;
  logic          kill_q, kill_d;
  logic [AW:0]   count_q, count_d;
  logic [AW-1:0] rdPtr_q, rdPtr_d;
  logic [AW-1:0] wrPtr_q, wrPtr_d;
  logic [31:0]   instrMem_q [DEPTH];
  logic [31:0]   pcMem_q    [DEPTH];

  logic          headValid;
  logic          popEn;
  logic          pushEn;
  logic          issueEn;
  logic [AW+1:0] occupancy;

  // Handshake and issue decisions; a slot is reserved for every request in flight
  // so a response can never land in a full buffer.
  always_comb begin
    occupancy = {1'b0, count_q} + {{(AW+1){1'b0}}, inflight_q};
    headValid = (count_q != '0);
    popEn     = headValid & instr_ready;
    pushEn    = inflight_q & ~kill_q & ~redirect;
    issueEn   = rst_n & ~redirect &
                ((occupancy < DEPTH_OCC) | ((occupancy == DEPTH_OCC) & popEn));
  end

  // Next-state for PC, in-flight tracking and FIFO bookkeeping; redirect overrides all.
  always_comb begin
    pc_d         = pc_q;
    inflight_d   = issueEn;
    inflightPc_d = inflightPc_q;
    kill_d       = 1'b0;
    count_d      = count_q;
    rdPtr_d      = rdPtr_q;
    wrPtr_d      = wrPtr_q;
    if (issueEn) begin
      inflightPc_d = pc_q;
    end
    if (redirect) begin
      pc_d    = redirect_pc & ~32'h3;
      kill_d  = inflight_q;
      count_d = '0;
      rdPtr_d = '0;
      wrPtr_d = '0;
    end else begin
      if (issueEn) begin
        pc_d = pc_q + 32'd4;
      end
      if (pushEn) begin
        wrPtr_d = wrPtr_q + AW'(1);
      end
      if (popEn) begin
        rdPtr_d = rdPtr_q + AW'(1);
      end
      case ({pushEn, popEn})
        2'b10:   count_d = count_q + (AW+1)'(1);
        2'b01:   count_d = count_q - (AW+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q         <= RESET_PC;
      inflight_q   <= 1'b0;
      inflightPc_q <= '0;
      kill_q       <= 1'b0;
      count_q      <= '0;
      rdPtr_q      <= '0;
      wrPtr_q      <= '0;
    end else begin
      pc_q         <= pc_d;
      inflight_q   <= inflight_d;
      inflightPc_q <= inflightPc_d;
      kill_q       <= kill_d;
      count_q      <= count_d;
      rdPtr_q      <= rdPtr_d;
      wrPtr_q      <= wrPtr_d;
    end
  end

  // Buffer storage: the returned word is written together with the PC it was fetched from.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        instrMem_q[i] <= '0;
        pcMem_q[i]    <= '0;
      end
    end else if (pushEn) begin
      instrMem_q[wrPtr_q] <= imem_rdata;
      pcMem_q[wrPtr_q]    <= inflightPc_q;
    end
  end

  assign imem_req    = issueEn;
  assign imem_addr   = pc_q;
  assign instr       = instrMem_q[rdPtr_q];
  assign instr_pc    = pcMem_q[rdPtr_q];
  assign instr_valid = headValid;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed testbench for fetch_unit with a 1-cycle synchronous memory model.
module tb_fetch_unit;

   localparam int DEPTH = 2;

   logic        clk;
   logic        rst_n;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic        instr_valid;
   logic        instr_ready;
   logic        redirect;
   logic [31:0] redirect_pc;

   int testsRun;
   int testsFailed;

   fetch_unit #(
      .RESET_PC(32'h0000_0000),
      .DEPTH   (DEPTH)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .imem_rdata (imem_rdata),
      .instr      (instr),
      .instr_pc   (instr_pc),
      .instr_valid(instr_valid),
      .instr_ready(instr_ready),
      .redirect   (redirect),
      .redirect_pc(redirect_pc)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Memory contents: word at byte address a is 0x1000_0000 + a/4.
   function automatic logic [31:0] memWord(input logic [31:0] addr);
      return 32'h1000_0000 + (addr >> 2);
   endfunction

   // Instruction memory: data for a request appears in the following cycle.
   always @(posedge clk) begin
      if (imem_req) imem_rdata <= memWord(imem_addr);
   end

   // Single comparison point: counts every check and reports any mismatch.
   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      testsRun++;
      if (actual !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %08h, expected %08h at %0t", tag, actual, expected, $time);
      end
   endtask

   // A response must never be written into a full buffer unless the head leaves that cycle.
   always @(negedge clk) begin
      if (rst_n && dut.pushEn && !dut.popEn && (dut.count_q == (DEPTH+1)'(DEPTH)))
         checkOutput("noPushFull", 32'd1, 32'd0);
   end

   // Advance to the next cycle, drive its inputs, then let combinational outputs settle.
   task automatic applyStimulus(input logic ready, input logic redir, input logic [31:0] rpc);
      @(posedge clk);
      #1;
      instr_ready = ready;
      redirect    = redir;
      redirect_pc = rpc;
      #1;
   endtask

   // Release reset one time unit after a rising edge; that interval is cycle 0.
   task automatic releaseReset(input logic ready);
      @(posedge clk);
      #1;
      rst_n       = 1'b1;
      instr_ready = ready;
      redirect    = 1'b0;
      redirect_pc = 32'h0;
      #1;
   endtask

   task automatic checkReq(input string tag, input logic [31:0] addr);
      checkOutput({tag, ".req"}, {31'd0, imem_req}, 32'd1);
      checkOutput({tag, ".addr"}, imem_addr, addr);
   endtask

   task automatic checkHead(input string tag, input logic [31:0] pc);
      checkOutput({tag, ".valid"}, {31'd0, instr_valid}, 32'd1);
      checkOutput({tag, ".pc"}, instr_pc, pc);
      checkOutput({tag, ".instr"}, instr, memWord(pc));
   endtask

   initial begin
      testsRun    = 0;
      testsFailed = 0;
      rst_n       = 1'b0;
      instr_ready = 1'b0;
      redirect    = 1'b0;
      redirect_pc = 32'h0;
      imem_rdata  = 32'h0;

      // Reset values, before any clock edge.
      #2;
      checkOutput("rst.req", {31'd0, imem_req}, 32'd0);
      checkOutput("rst.valid", {31'd0, instr_valid}, 32'd0);
      checkOutput("rst.instr", instr, 32'h0);
      checkOutput("rst.instrPc", instr_pc, 32'h0);
      checkOutput("rst.addr", imem_addr, 32'h0);

      // Streaming with decode always ready: one instruction per cycle from cycle 2.
      releaseReset(1'b1);
      for (int k = 0; k < 12; k++) begin
         if (k > 0) applyStimulus(1'b1, 1'b0, 32'h0);
         checkReq($sformatf("stream%0d", k), 32'(4 * k));
         if (k < 2) checkOutput($sformatf("stream%0d.valid", k), {31'd0, instr_valid}, 32'd0);
         else checkHead($sformatf("stream%0d", k), 32'(4 * (k - 2)));
      end

      // Asynchronous reset between edges mid-stream.
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("midRst.valid", {31'd0, instr_valid}, 32'd0);
      checkOutput("midRst.req", {31'd0, imem_req}, 32'd0);
      checkOutput("midRst.addr", imem_addr, 32'h0);
      @(posedge clk);
      #3;

      // Decode stalled from cycle 2: only two requests, then delivery in order from cycle 8.
      releaseReset(1'b0);
      checkReq("stall0", 32'h0);
      applyStimulus(1'b0, 1'b0, 32'h0);
      checkReq("stall1", 32'h4);
      for (int k = 2; k < 8; k++) begin
         applyStimulus(1'b0, 1'b0, 32'h0);
         checkOutput($sformatf("stall%0d.noReq", k), {31'd0, imem_req}, 32'd0);
         checkHead($sformatf("stall%0d", k), 32'h0);
      end
      applyStimulus(1'b1, 1'b0, 32'h0);
      checkReq("stall8", 32'h8);
      checkHead("stall8", 32'h0);
      applyStimulus(1'b1, 1'b0, 32'h0);
      checkReq("stall9", 32'hC);
      checkHead("stall9", 32'h4);
      applyStimulus(1'b1, 1'b0, 32'h0);
      checkHead("stall10", 32'h8);
      applyStimulus(1'b1, 1'b0, 32'h0);
      checkHead("stall11", 32'hC);

      // Redirect to 0x40 while one entry is buffered and one request is in flight.
      rst_n = 1'b0;
      #1;
      releaseReset(1'b0);
      checkReq("redir0", 32'h0);
      applyStimulus(1'b0, 1'b0, 32'h0);
      checkReq("redir1", 32'h4);
      applyStimulus(1'b0, 1'b1, 32'h40);
      checkOutput("redir2.noReq", {31'd0, imem_req}, 32'd0);
      checkHead("redir2", 32'h0);
      applyStimulus(1'b1, 1'b0, 32'h0);
      checkOutput("redir3.valid", {31'd0, instr_valid}, 32'd0);
      checkReq("redir3", 32'h40);
      applyStimulus(1'b1, 1'b0, 32'h0);
      checkOutput("redir4.valid", {31'd0, instr_valid}, 32'd0);
      checkReq("redir4", 32'h44);
      applyStimulus(1'b1, 1'b0, 32'h0);
      checkHead("redir5", 32'h40);
      applyStimulus(1'b1, 1'b1, 32'h43);
      checkHead("redir6", 32'h44);
      checkOutput("redir6.noReq", {31'd0, imem_req}, 32'd0);

      // Misaligned target is aligned down.
      applyStimulus(1'b1, 1'b0, 32'h0);
      checkOutput("align.valid", {31'd0, instr_valid}, 32'd0);
      checkReq("align", 32'h40);

      // Back-to-back redirect kills the 0x40 fetch; PC wraps past the top of memory.
      applyStimulus(1'b1, 1'b1, 32'hFFFF_FFFC);
      checkOutput("wrap0.noReq", {31'd0, imem_req}, 32'd0);
      checkOutput("wrap0.valid", {31'd0, instr_valid}, 32'd0);
      applyStimulus(1'b1, 1'b0, 32'h0);
      checkOutput("wrap1.valid", {31'd0, instr_valid}, 32'd0);
      checkReq("wrap1", 32'hFFFF_FFFC);
      applyStimulus(1'b1, 1'b0, 32'h0);
      checkOutput("wrap2.valid", {31'd0, instr_valid}, 32'd0);
      checkReq("wrap2", 32'h0);
      applyStimulus(1'b1, 1'b0, 32'h0);
      checkHead("wrap3", 32'hFFFF_FFFC);
      checkOutput("wrap3.word", instr, 32'h4FFF_FFFF);
      applyStimulus(1'b1, 1'b0, 32'h0);
      checkHead("wrap4", 32'h0);
      checkOutput("wrap4.word", instr, 32'h1000_0000);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
